// File: rtl/mem_arbiter_2to1_if.sv
// rtl/mem_arbiter_2to1_if.sv - IC/DM requester ports and shared memory bus of the 2:1 arbiter
interface mem_arbiter_2to1_if #(
    parameter int XLEN = 32
);
    logic            i_ic_req;
    logic [XLEN-1:0] i_ic_addr;
    logic [XLEN-1:0] o_ic_data;
    logic            o_ic_ready;

    logic            i_dm_rd;
    logic            i_dm_wen;
    logic [XLEN-1:0] i_dm_addr;
    logic [XLEN-1:0] i_dm_wd;
    logic [3:0]      i_dm_byte_en;
    logic [XLEN-1:0] o_dm_rdata;
    logic            o_dm_ready;

    logic            o_bus_req;
    logic            o_bus_wen;
    logic [XLEN-1:0] o_bus_addr;
    logic [XLEN-1:0] o_bus_wd;
    logic [3:0]      o_bus_byte_en;
    logic [XLEN-1:0] i_bus_rdata;
    logic            i_bus_ack;
    logic            o_timeout;

    modport master (
        input  i_ic_req, i_ic_addr,
        output o_ic_data, o_ic_ready,
        input  i_dm_rd, i_dm_wen, i_dm_addr, i_dm_wd, i_dm_byte_en,
        output o_dm_rdata, o_dm_ready,
        output o_bus_req, o_bus_wen, o_bus_addr, o_bus_wd, o_bus_byte_en,
        input  i_bus_rdata, i_bus_ack,
        output o_timeout
    );

    modport slave (
        output i_ic_req, i_ic_addr,
        input  o_ic_data, o_ic_ready,
        output i_dm_rd, i_dm_wen, i_dm_addr, i_dm_wd, i_dm_byte_en,
        input  o_dm_rdata, o_dm_ready,
        input  o_bus_req, o_bus_wen, o_bus_addr, o_bus_wd, o_bus_byte_en,
        output i_bus_rdata, i_bus_ack,
        input  o_timeout
    );
endinterface

// File: rtl/mem_arbiter_2to1.sv
// rtl/mem_arbiter_2to1.sv - round-robin 2:1 arbiter of IC refill and DM onto one memory bus
module mem_arbiter_2to1 #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mem_arbiter_2to1_if.master    arb
);
    typedef enum logic [2:0] {IDLE, BUSY_IC, BUSY_DM, RESP_IC, RESP_DM} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t           state;
    logic             last_dm;
    logic [CNT_W-1:0] cnt;
    logic             dm_req;
    logic             grant_dm;
    logic             cnt_done;

    assign dm_req   = arb.i_dm_rd | arb.i_dm_wen;
    // DM wins ties unless it had the previous grant
    assign grant_dm = dm_req & (~arb.i_ic_req | ~last_dm);
    // Fires on the TIMEOUT-th bus cycle; an ack in that same cycle takes priority
    assign cnt_done = (cnt + CNT_W'(1)) == TIMEOUT_CNT;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state             <= IDLE;
            last_dm           <= 1'b0;
            cnt               <= '0;
            arb.o_ic_data     <= '0;
            arb.o_ic_ready    <= 1'b0;
            arb.o_dm_rdata    <= '0;
            arb.o_dm_ready    <= 1'b0;
            arb.o_bus_req     <= 1'b0;
            arb.o_bus_wen     <= 1'b0;
            arb.o_bus_addr    <= '0;
            arb.o_bus_wd      <= '0;
            arb.o_bus_byte_en <= 4'b0000;
            arb.o_timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_dm) begin
                        state             <= BUSY_DM;
                        last_dm           <= 1'b1;
                        arb.o_bus_req     <= 1'b1;
                        arb.o_bus_wen     <= arb.i_dm_wen;
                        arb.o_bus_addr    <= arb.i_dm_addr;
                        arb.o_bus_wd      <= arb.i_dm_wd;
                        arb.o_bus_byte_en <= arb.i_dm_byte_en;
                    end else if (arb.i_ic_req) begin
                        state             <= BUSY_IC;
                        last_dm           <= 1'b0;
                        arb.o_bus_req     <= 1'b1;
                        arb.o_bus_wen     <= 1'b0;
                        arb.o_bus_addr    <= arb.i_ic_addr;
                        arb.o_bus_wd      <= '0;
                        arb.o_bus_byte_en <= 4'b1111;
                    end
                end
                BUSY_IC, BUSY_DM: begin
                    if (arb.i_bus_ack || cnt_done) begin
                        arb.o_bus_req <= 1'b0;
                        arb.o_timeout <= ~arb.i_bus_ack;
                        cnt           <= '0;
                        if (state == BUSY_IC) begin
                            state          <= RESP_IC;
                            arb.o_ic_ready <= 1'b1;
                            arb.o_ic_data  <= arb.i_bus_ack ? arb.i_bus_rdata : '0;
                        end else begin
                            state          <= RESP_DM;
                            arb.o_dm_ready <= 1'b1;
                            arb.o_dm_rdata <= arb.i_bus_ack ? arb.i_bus_rdata : '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP_IC, RESP_DM: begin
                    state          <= IDLE;
                    arb.o_ic_ready <= 1'b0;
                    arb.o_dm_ready <= 1'b0;
                    arb.o_timeout  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// tb/tb_mem_arbiter_2to1.sv - directed scoreboard bench for mem_arbiter_2to1
module tb_mem_arbiter_2to1;
    typedef struct {
        logic        is_dm;
        logic [31:0] data;
        logic        to;
    } resp_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ic_pulses = 0;
    int   dm_pulses = 0;
    resp_t exp_q[$];

    mem_arbiter_2to1_if #(.XLEN(32)) bus_if ();

    mem_arbiter_2to1 #(.XLEN(32), .TIMEOUT(4), .CNT_W(8)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .arb   (bus_if.master)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic is_dm, input logic [31:0] data, input logic to);
        resp_t r;
        r.is_dm = is_dm;
        r.data  = data;
        r.to    = to;
        exp_q.push_back(r);
    endtask

    // Act as the slave: ack on the ack_at-th bus cycle (0 = never), count bus cycles
    task automatic serve(input int ack_at, input logic [31:0] rd, output int busy);
        busy = 0;
        for (int c = 0; c < 20; c++) begin
            if (!bus_if.o_bus_req) break;
            busy++;
            if (busy == ack_at) begin
                bus_if.i_bus_ack   = 1'b1;
                bus_if.i_bus_rdata = rd;
            end
            tick();
            bus_if.i_bus_ack = 1'b0;
        end
    endtask

    // Response scoreboard: every ready pulse must match the oldest expected response
    always @(negedge i_clk) begin
        if (bus_if.o_ic_ready) ic_pulses++;
        if (bus_if.o_dm_ready) dm_pulses++;
        if (bus_if.o_ic_ready || bus_if.o_dm_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", {30'd0, bus_if.o_ic_ready, bus_if.o_dm_ready}, 32'd0);
            end else begin
                resp_t r;
                r = exp_q.pop_front();
                check("ready_port_dm", {31'd0, bus_if.o_dm_ready}, {31'd0, r.is_dm});
                check("ready_port_ic", {31'd0, bus_if.o_ic_ready}, {31'd0, ~r.is_dm});
                check("resp_data", r.is_dm ? bus_if.o_dm_rdata : bus_if.o_ic_data, r.data);
                check("resp_timeout", {31'd0, bus_if.o_timeout}, {31'd0, r.to});
            end
        end else if (bus_if.o_timeout) begin
            check("timeout_without_ready", {31'd0, bus_if.o_timeout}, 32'd0);
        end
    end

    initial begin
        int busy;
        int ic0;
        bus_if.i_ic_req     = 1'b0;
        bus_if.i_ic_addr    = '0;
        bus_if.i_dm_rd      = 1'b0;
        bus_if.i_dm_wen     = 1'b0;
        bus_if.i_dm_addr    = '0;
        bus_if.i_dm_wd      = '0;
        bus_if.i_dm_byte_en = 4'b0000;
        bus_if.i_bus_rdata  = '0;
        bus_if.i_bus_ack    = 1'b0;
        tick();
        tick();
        check("rst_bus_req", {31'd0, bus_if.o_bus_req}, 32'd0);
        check("rst_ready", {30'd0, bus_if.o_ic_ready, bus_if.o_dm_ready}, 32'd0);
        check("rst_timeout", {31'd0, bus_if.o_timeout}, 32'd0);
        check("rst_ic_data", bus_if.o_ic_data, 32'd0);
        check("rst_dm_rdata", bus_if.o_dm_rdata, 32'd0);
        check("rst_bus_addr", bus_if.o_bus_addr, 32'd0);
        check("rst_bus_wd", bus_if.o_bus_wd, 32'd0);
        check("rst_bus_ctl", {27'd0, bus_if.o_bus_wen, bus_if.o_bus_byte_en}, 32'd0);
        i_rst = 1'b1;
        tick();

        // IC refill, ack on the 3rd bus cycle; live address changes must not leak onto the bus
        bus_if.i_ic_req  = 1'b1;
        bus_if.i_ic_addr = 32'h0000_0100;
        tick();
        check("ic_grant_req", {31'd0, bus_if.o_bus_req}, 32'd1);
        check("ic_grant_wen", {31'd0, bus_if.o_bus_wen}, 32'd0);
        check("ic_grant_be", {28'd0, bus_if.o_bus_byte_en}, 32'hF);
        check("ic_grant_addr", bus_if.o_bus_addr, 32'h0000_0100);
        push(1'b0, 32'h0000_0013, 1'b0);
        bus_if.i_ic_addr = 32'hFFFF_FFFF;
        serve(3, 32'h0000_0013, busy);
        check("ic_busy_cycles", busy, 32'd3);
        check("ic_addr_latched", bus_if.o_bus_addr, 32'h0000_0100);
        bus_if.i_ic_req = 1'b0;
        tick();
        check("ic_pulse_count", ic_pulses, 32'd1);
        check("ic_no_dm_pulse", dm_pulses, 32'd0);

        // DM write with immediate ack
        bus_if.i_dm_wen     = 1'b1;
        bus_if.i_dm_addr    = 32'h8000_0004;
        bus_if.i_dm_wd      = 32'hDEAD_BEEF;
        bus_if.i_dm_byte_en = 4'b0011;
        tick();
        check("dmw_wen", {31'd0, bus_if.o_bus_wen}, 32'd1);
        check("dmw_addr", bus_if.o_bus_addr, 32'h8000_0004);
        check("dmw_wd", bus_if.o_bus_wd, 32'hDEAD_BEEF);
        check("dmw_be", {28'd0, bus_if.o_bus_byte_en}, 32'h3);
        push(1'b1, 32'h0000_0055, 1'b0);
        serve(1, 32'h0000_0055, busy);
        check("dmw_busy_cycles", busy, 32'd1);
        bus_if.i_dm_wen = 1'b0;
        tick();
        check("dmw_ic_data_held", bus_if.o_ic_data, 32'h0000_0013);

        // Simultaneous requests from a fresh reset: DM, IC, DM with a 2-cycle bus gap
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        bus_if.i_ic_req     = 1'b1;
        bus_if.i_ic_addr    = 32'h0000_0200;
        bus_if.i_dm_rd      = 1'b1;
        bus_if.i_dm_addr    = 32'h0000_3000;
        bus_if.i_dm_byte_en = 4'b1111;
        tick();
        check("rr1_dm_first", bus_if.o_bus_addr, 32'h0000_3000);
        push(1'b1, 32'h1111_1111, 1'b0);
        serve(1, 32'h1111_1111, busy);
        tick();
        check("rr_gap1", {31'd0, bus_if.o_bus_req}, 32'd0);
        tick();
        check("rr2_ic_next", bus_if.o_bus_addr, 32'h0000_0200);
        check("rr2_req", {31'd0, bus_if.o_bus_req}, 32'd1);
        push(1'b0, 32'h2222_2222, 1'b0);
        serve(1, 32'h2222_2222, busy);
        tick();
        tick();
        check("rr3_dm_again", bus_if.o_bus_addr, 32'h0000_3000);
        push(1'b1, 32'h3333_3333, 1'b0);
        serve(2, 32'h3333_3333, busy);
        bus_if.i_ic_req = 1'b0;
        bus_if.i_dm_rd  = 1'b0;
        tick();

        // Timeout: no ack for TIMEOUT=4 cycles, then ack exactly on the 4th cycle
        bus_if.i_dm_rd   = 1'b1;
        bus_if.i_dm_addr = 32'h0000_4000;
        tick();
        push(1'b1, 32'h0000_0000, 1'b1);
        serve(0, 32'h0, busy);
        check("to_busy_cycles", busy, 32'd4);
        bus_if.i_dm_rd = 1'b0;
        tick();
        bus_if.i_dm_rd = 1'b1;
        tick();
        push(1'b1, 32'hA5A5_A5A5, 1'b0);
        serve(4, 32'hA5A5_A5A5, busy);
        check("ack_at_limit_cycles", busy, 32'd4);
        bus_if.i_dm_rd = 1'b0;
        tick();

        // Reset mid BUSY_IC aborts silently; re-request completes normally
        ic0 = ic_pulses;
        bus_if.i_ic_req  = 1'b1;
        bus_if.i_ic_addr = 32'h0000_0500;
        tick();
        tick();
        i_rst = 1'b0;
        tick();
        check("rst_mid_bus_req", {31'd0, bus_if.o_bus_req}, 32'd0);
        check("rst_mid_no_ready", ic_pulses, ic0);
        i_rst = 1'b1;
        tick();
        check("rerequest_grant", {31'd0, bus_if.o_bus_req}, 32'd1);
        push(1'b0, 32'h0000_0777, 1'b0);
        serve(2, 32'h0000_0777, busy);
        bus_if.i_ic_req = 1'b0;
        tick();
        check("rerequest_pulse", ic_pulses, ic0 + 1);

        // Stray ack in IDLE, then a request dropped right after its grant
        bus_if.i_bus_ack   = 1'b1;
        bus_if.i_bus_rdata = 32'hBAD0_BAD0;
        tick();
        bus_if.i_bus_ack = 1'b0;
        check("stray_ack_idle", {31'd0, bus_if.o_bus_req}, 32'd0);
        check("stray_ack_data", bus_if.o_ic_data, 32'h0000_0777);
        ic0 = ic_pulses;
        bus_if.i_ic_req = 1'b1;
        tick();
        bus_if.i_ic_req = 1'b0;
        push(1'b0, 32'h0000_0888, 1'b0);
        serve(2, 32'h0000_0888, busy);
        tick();
        tick();
        tick();
        check("dropped_single_pulse", ic_pulses, ic0 + 1);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
